// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter sequencer:
// next-PC source encoding and the return-stack pointer-width helper.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_CALL = 3'd2,
    SEL_RET  = 3'd3,
    SEL_HOLD = 3'd4
  } pc_sel_e;

  // Ceiling log2, evaluated at elaboration to size the return-stack pointer.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Constant-step ripple incrementer: a full-adder chain whose addend bits
// are fixed by STEP. Carry-in is 0 and the carry-out is dropped (mod 2^WIDTH).
module pc_incr #(
  parameter int WIDTH = 16,
  parameter int STEP  = 2
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] pc_next_o
);

  localparam logic [WIDTH-1:0] ADDEND = WIDTH'(STEP);

  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    logic a_b;
    logic b_b;
    assign a_b           = pc_i[gi];
    assign b_b           = ADDEND[gi];
    assign pc_next_o[gi] = a_b ^ b_b ^ carry[gi];
    if (gi < WIDTH - 1) begin : g_carry
      assign carry[gi+1] = (a_b & b_b) | (carry[gi] & (a_b ^ b_b));
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with sequential/branch/call/return selection and a
// small circular return-address stack carrying sticky overflow/underflow flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Branch,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Call,
  input  logic             Ret,
  input  logic             ClearErr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCNext,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasOverflow,
  output logic             RasUnderflow
);

  localparam int PTR_W = clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] pc_next;
  pc_sel_e          sel;
  logic             underflow_evt;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  pc_incr #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_incr (
    .pc_i      (pc_q),
    .pc_next_o (pc_next)
  );

  always_comb begin
    sel           = SEL_SEQ;
    underflow_evt = 1'b0;
    if (Stall) begin
      sel = SEL_HOLD;
    end else if (Ret) begin
      // An empty-stack return falls through to the sequential address.
      if (cnt_q != '0) sel = SEL_RET;
      else             underflow_evt = 1'b1;
    end else if (Call) begin
      sel = SEL_CALL;
    end else if (Branch) begin
      sel = SEL_BR;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ClearErr ? 1'b0 : ovf_q;
    unf_d = ClearErr ? 1'b0 : unf_q;
    case (sel)
      SEL_SEQ:  pc_d = pc_next;
      SEL_BR:   pc_d = BranchTarget;
      SEL_RET: begin
        pc_d  = ras_mem[top_q];
        top_d = top_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
      SEL_CALL: begin
        pc_d  = BranchTarget;
        top_d = top_q + 1'b1;
        if (cnt_q == CNT_FULL) ovf_d = 1'b1;
        else                   cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
    if (underflow_evt) unf_d = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage is never reset; the Reset gate keeps an aborted push out.
  always_ff @(posedge Clock) begin
    if (!Reset && sel == SEL_CALL) ras_mem[top_q + 1'b1] <= pc_next;
  end

  assign PC           = pc_q;
  assign PCNext       = pc_next;
  assign RasEmpty     = (cnt_q == '0);
  assign RasFull      = (cnt_q == CNT_FULL);
  assign RasOverflow  = ovf_q;
  assign RasUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the return stack.
module tb_pc_sequencer;

  localparam int WIDTH     = 16;
  localparam int STEP      = 2;
  localparam int RESET_VEC = 0;
  localparam int RAS_DEPTH = 4;
  localparam int MASK      = (1 << WIDTH) - 1;

  logic             Clock;
  logic             Reset;
  logic             Stall;
  logic             Branch;
  logic [WIDTH-1:0] BranchTarget;
  logic             Call;
  logic             Ret;
  logic             ClearErr;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PCNext;
  logic             RasEmpty;
  logic             RasFull;
  logic             RasOverflow;
  logic             RasUnderflow;

  pc_sequencer #(
    .WIDTH     (WIDTH),
    .STEP      (STEP),
    .RESET_VEC (16'(RESET_VEC)),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Stall        (Stall),
    .Branch       (Branch),
    .BranchTarget (BranchTarget),
    .Call         (Call),
    .Ret          (Ret),
    .ClearErr     (ClearErr),
    .PC           (PC),
    .PCNext       (PCNext),
    .RasEmpty     (RasEmpty),
    .RasFull      (RasFull),
    .RasOverflow  (RasOverflow),
    .RasUnderflow (RasUnderflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the stack is a queue holding at most RAS_DEPTH entries.
  int m_pc;
  int m_stack[$];
  bit m_ovf;
  bit m_unf;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_VEC;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit br, input int tgt,
                            input bit cl, input bit rt, input bit clr);
    int seq;
    seq = (m_pc + STEP) & MASK;
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (!st) begin
      if (rt) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc  = seq;
          m_unf = 1'b1;
        end
      end else if (cl) begin
        m_stack.push_back(seq);
        if (m_stack.size() > RAS_DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = tgt;
      end else if (br) begin
        m_pc = tgt;
      end else begin
        m_pc = seq;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    int'(PC), m_pc);
    check({tag, ".pcnx"},  int'(PCNext), (m_pc + STEP) & MASK);
    check({tag, ".empty"}, int'(RasEmpty), int'(m_stack.size() == 0));
    check({tag, ".full"},  int'(RasFull), int'(m_stack.size() == RAS_DEPTH));
    check({tag, ".ovf"},   int'(RasOverflow), int'(m_ovf));
    check({tag, ".unf"},   int'(RasUnderflow), int'(m_unf));
  endtask

  // One transaction: drive, clock, advance model, then compare 1 ns after the edge.
  task automatic cycle(input string tag, input bit st, input bit br, input int tgt,
                       input bit cl, input bit rt, input bit clr);
    Stall        = st;
    Branch       = br;
    BranchTarget = WIDTH'(tgt);
    Call         = cl;
    Ret          = rt;
    ClearErr     = clr;
    @(posedge Clock);
    model_step(st, br, tgt, cl, rt, clr);
    #1;
    $display("%s st=%0b br=%0b cl=%0b rt=%0b clr=%0b tgt=%04h -> PC=%04h", tag, st, br, cl,
             rt, clr, tgt[15:0], PC);
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    Stall = 1'b0; Branch = 1'b0; BranchTarget = '0;
    Call = 1'b0; Ret = 1'b0; ClearErr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    Reset = 1'b0;

    for (int i = 0; i < 4; i++) idle("free");

    cycle("br_fffc", 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b0);
    idle("wrap1");
    idle("wrap2");

    cycle("br_40", 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);
    cycle("call_1000", 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0);
    cycle("ret", 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);

    for (int i = 1; i <= 5; i++) cycle("nest_call", 1'b0, 1'b0, i * 16'h100, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("nest_ret", 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);

    cycle("clr", 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    cycle("call_2000", 1'b0, 1'b0, 16'h2000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b1, 16'h3000, 1'b0, 1'b1, 1'b0);
    cycle("ret_call_br", 1'b0, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b0);
    cycle("clr_unf", 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    cycle("stall_clr", 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset landing 1 ns after a Call edge, then held across an edge.
    cycle("pre_rst_call", 1'b0, 1'b0, 16'h5000, 1'b1, 1'b0, 1'b0);
    Call = 1'b1; BranchTarget = 16'h6000;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge Clock);
    #1;
    check_all("rst_held");
    Call = 1'b0;
    #2;
    Reset = 1'b0;
    idle("post_rst");

    for (int i = 0; i < 400; i++) begin
      bit st, br, cl, rt, clr;
      int tgt;
      st  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 3) == 0);
      cl  = ($urandom_range(0, 3) == 0);
      rt  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 11) == 0);
      tgt = int'($urandom_range(0, MASK));
      cycle("rand", st, br, tgt, cl, rt, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
